// File: rtl/rmii_packet_rx.sv
// RMII receive path: preamble/SFD detection, Ethernet/IPv4/UDP header filtering,
// UDP payload streamed as AXI-Stream bytes, FCS check and per-frame status.
module rmii_packet_rx #(
    parameter logic [47:0] FPGA_MAC        = 48'he86a64e7e830,
    parameter logic [31:0] FPGA_IP         = 32'hC0A80164,
    parameter logic [15:0] FPGA_PORT       = 16'h4567,
    parameter int          MAX_FRAME_BYTES = 1518
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        CRS_DV,
    input  logic [1:0]  RXD,
    output logic [7:0]  M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    output logic        RX_DONE,
    output logic        RX_FCS_OK,
    output logic        RX_ACCEPT,
    output logic        RX_LEN_ERR,
    output logic [10:0] RX_LEN
);

    localparam int          CW          = $clog2(MAX_FRAME_BYTES + 2);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TRAILER, S_DISCARD, S_FIN
    } state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    logic          crs_q;
    logic [1:0]    rxd_q;
    state_t        state;
    logic          armed;
    logic          seen01;
    logic          sfd_seen;
    logic [1:0]    phase;
    logic [5:0]    shreg;
    logic [CW-1:0] byte_cnt;
    logic [31:0]   crc;
    logic [47:0]   dst_mac;
    logic [15:0]   eth_type;
    logic [7:0]    ver_ihl;
    logic [7:0]    proto;
    logic [31:0]   dst_ip;
    logic [15:0]   dst_port;
    logic [15:0]   udp_len;
    logic [15:0]   remaining;
    logic [10:0]   rx_len;
    logic          accept;
    logic          len_err;
    logic          fcs_ok;

    logic [7:0]  byte_now;
    logic        byte_done;
    logic        frame_over;
    logic [5:0]  hidx;
    logic [31:0] crc_now;
    logic        hdr_pass;

    // NOTE: the input sampling flops carry no reset on purpose, so that after a
    // mid-frame reset 'armed' only ever sees genuine CRS_DV samples.
    always_ff @(posedge CLK) begin
        crs_q <= CRS_DV;
        rxd_q <= RXD;
    end

    assign byte_now   = {rxd_q, shreg};
    assign byte_done  = crs_q && (phase == 2'd3);
    assign frame_over = (byte_cnt == CW'(MAX_FRAME_BYTES));
    assign hidx       = byte_cnt[5:0];
    assign crc_now    = crc_byte(crc, byte_now);
    assign hdr_pass   = ((dst_mac == FPGA_MAC) || (dst_mac == 48'hFFFFFFFFFFFF)) &&
                        (eth_type == 16'h0800) && (ver_ihl == 8'h45) &&
                        (proto == 8'h11) && (dst_ip == FPGA_IP) && (dst_port == FPGA_PORT);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= S_IDLE;
            armed         <= 1'b0;
            seen01        <= 1'b0;
            sfd_seen      <= 1'b0;
            phase         <= 2'd0;
            shreg         <= 6'd0;
            byte_cnt      <= '0;
            crc           <= 32'hFFFFFFFF;
            dst_mac       <= 48'd0;
            eth_type      <= 16'd0;
            ver_ihl       <= 8'd0;
            proto         <= 8'd0;
            dst_ip        <= 32'd0;
            dst_port      <= 16'd0;
            udp_len       <= 16'd0;
            remaining     <= 16'd0;
            rx_len        <= 11'd0;
            accept        <= 1'b0;
            len_err       <= 1'b0;
            fcs_ok        <= 1'b0;
            M_AXIS_TDATA  <= 8'd0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            RX_DONE       <= 1'b0;
            RX_FCS_OK     <= 1'b0;
            RX_ACCEPT     <= 1'b0;
            RX_LEN_ERR    <= 1'b0;
            RX_LEN        <= 11'd0;
        end else begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            RX_DONE       <= 1'b0;
            RX_FCS_OK     <= 1'b0;
            RX_ACCEPT     <= 1'b0;
            RX_LEN_ERR    <= 1'b0;
            RX_LEN        <= 11'd0;
            armed         <= armed | ~crs_q;

            if (crs_q && (state inside {S_HEADER, S_PAYLOAD, S_TRAILER, S_DISCARD})) begin
                phase <= phase + 2'd1;
                shreg <= {rxd_q, shreg[5:2]};
            end

            case (state)
                S_IDLE: begin
                    if (crs_q && armed) begin
                        state    <= S_PREAMBLE;
                        seen01   <= 1'b0;
                        sfd_seen <= 1'b0;
                    end
                end

                S_PREAMBLE: begin
                    if (!crs_q) begin
                        state <= S_IDLE;
                    end else begin
                        case (rxd_q)
                            2'b00: if (seen01) state <= S_DISCARD;
                            2'b01: seen01 <= 1'b1;
                            2'b11: begin
                                if (seen01) begin
                                    state    <= S_HEADER;
                                    sfd_seen <= 1'b1;
                                    byte_cnt <= '0;
                                    phase    <= 2'd0;
                                    crc      <= 32'hFFFFFFFF;
                                    accept   <= 1'b0;
                                    len_err  <= 1'b0;
                                    rx_len   <= 11'd0;
                                end else begin
                                    state <= S_DISCARD;
                                end
                            end
                            default: state <= S_DISCARD;
                        endcase
                    end
                end

                S_HEADER, S_PAYLOAD, S_TRAILER: begin
                    if (!crs_q) begin
                        // Carrier loss before the trailer means the frame was cut short.
                        fcs_ok <= (crc == CRC_RESIDUE);
                        if (state != S_TRAILER) begin
                            len_err <= 1'b1;
                            accept  <= 1'b0;
                        end
                        if (phase != 2'd0)
                            len_err <= 1'b1;
                        state <= S_FIN;
                    end else if (byte_done && frame_over) begin
                        len_err <= 1'b1;
                        if (state == S_HEADER)
                            accept <= 1'b0;
                        state <= S_DISCARD;
                    end else if (byte_done) begin
                        byte_cnt <= byte_cnt + CW'(1);
                        crc      <= crc_now;
                        if (state == S_HEADER) begin
                            case (hidx)
                                6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5:
                                    dst_mac <= {dst_mac[39:0], byte_now};
                                6'd12, 6'd13: eth_type <= {eth_type[7:0], byte_now};
                                6'd14:        ver_ihl  <= byte_now;
                                6'd23:        proto    <= byte_now;
                                6'd30, 6'd31, 6'd32, 6'd33:
                                    dst_ip <= {dst_ip[23:0], byte_now};
                                6'd36, 6'd37: dst_port <= {dst_port[7:0], byte_now};
                                6'd38, 6'd39: udp_len  <= {udp_len[7:0], byte_now};
                                6'd41: begin
                                    if (hdr_pass) begin
                                        accept <= 1'b1;
                                        if (udp_len > 16'd8) begin
                                            remaining <= udp_len - 16'd8;
                                            state     <= S_PAYLOAD;
                                        end else begin
                                            len_err <= (udp_len < 16'd8);
                                            state   <= S_TRAILER;
                                        end
                                    end else begin
                                        accept <= 1'b0;
                                        state  <= S_TRAILER;
                                    end
                                end
                                default: ;
                            endcase
                        end else if (state == S_PAYLOAD) begin
                            M_AXIS_TDATA  <= byte_now;
                            M_AXIS_TVALID <= 1'b1;
                            remaining     <= remaining - 16'd1;
                            if (rx_len != 11'h7FF)
                                rx_len <= rx_len + 11'd1;
                            if (remaining == 16'd1) begin
                                M_AXIS_TLAST <= 1'b1;
                                state        <= S_TRAILER;
                            end
                        end
                    end
                end

                S_DISCARD: begin
                    if (!crs_q) begin
                        fcs_ok <= (crc == CRC_RESIDUE);
                        state  <= sfd_seen ? S_FIN : S_IDLE;
                    end
                end

                S_FIN: begin
                    RX_DONE    <= 1'b1;
                    RX_FCS_OK  <= fcs_ok;
                    RX_ACCEPT  <= accept;
                    RX_LEN_ERR <= len_err;
                    RX_LEN     <= rx_len;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_packet_rx.sv
// Directed bench for rmii_packet_rx: frames built with a local CRC model,
// expected payload bytes and frame status kept in scoreboard queues.
module tb_rmii_packet_rx;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic        fcs_ok;
        logic        fcs_care;
        logic        accept;
        logic        len_err;
        logic [10:0] len;
    } done_t;

    localparam logic [47:0] MAC   = 48'he86a64e7e830;
    localparam logic [31:0] IP    = 32'hC0A80164;
    localparam logic [15:0] PORT  = 16'h4567;
    localparam logic [31:0] RESID = 32'hDEBB20E3;

    logic        CLK;
    logic        reset;
    logic        CRS_DV;
    logic [1:0]  RXD;
    logic [7:0]  M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        RX_DONE;
    logic        RX_FCS_OK;
    logic        RX_ACCEPT;
    logic        RX_LEN_ERR;
    logic [10:0] RX_LEN;

    int checks = 0;
    int errors = 0;

    logic [7:0] frm[$];
    logic [7:0] pay[$];
    beat_t      exp_stream[$];
    done_t      exp_done[$];

    rmii_packet_rx dut (
        .CLK           (CLK),
        .reset         (reset),
        .CRS_DV        (CRS_DV),
        .RXD           (RXD),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .RX_DONE       (RX_DONE),
        .RX_FCS_OK     (RX_FCS_OK),
        .RX_ACCEPT     (RX_ACCEPT),
        .RX_LEN_ERR    (RX_LEN_ERR),
        .RX_LEN        (RX_LEN)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_over(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic push16(input logic [15:0] v);
        frm.push_back(v[15:8]);
        frm.push_back(v[7:0]);
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] pr,
                         input logic [31:0] ip, input logic [15:0] port, input logic [15:0] ulen);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(mac[8*(5-i) +: 8]);
        push16(16'h0200); push16(16'h0000); push16(16'h0001);
        push16(et);
        frm.push_back(8'h45); frm.push_back(8'h00);
        push16(16'd20 + ulen);
        push16(16'h0000); push16(16'h4000);
        frm.push_back(8'h40); frm.push_back(pr);
        push16(16'h0000);
        push16(16'hC0A8); push16(16'h0102);
        for (int i = 0; i < 4; i++) frm.push_back(ip[8*(3-i) +: 8]);
        push16(16'h1000); push16(port); push16(ulen); push16(16'h0000);
        foreach (pay[i]) frm.push_back(pay[i]);
        while (frm.size() < 60) frm.push_back(8'h00);
        c = ~crc_over(frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic drive(input logic [1:0] d, input logic dv);
        @(negedge CLK);
        CRS_DV = dv;
        RXD    = d;
    endtask

    task automatic send(input int nbytes, input bit bad_pre, input bit end_frame);
        logic [7:0] b;
        for (int i = 0; i < 28; i++) drive((bad_pre && i == 6) ? 2'b10 : 2'b01, 1'b1);
        drive(2'b01, 1'b1); drive(2'b01, 1'b1); drive(2'b01, 1'b1); drive(2'b11, 1'b1);
        for (int i = 0; i < nbytes; i++) begin
            b = frm[i];
            for (int k = 0; k < 4; k++) drive(b[2*k +: 2], 1'b1);
        end
        if (end_frame)
            for (int i = 0; i < 48; i++) drive(2'b00, 1'b0);
    endtask

    task automatic expect_stream(input int n, input bit with_last);
        beat_t s;
        for (int i = 0; i < n; i++) begin
            s.data = frm[42+i];
            s.last = with_last && (i == n - 1);
            exp_stream.push_back(s);
        end
    endtask

    task automatic expect_done(input bit fcs, input bit care, input bit acc, input bit lerr, input int len);
        done_t d;
        d.fcs_ok = fcs; d.fcs_care = care; d.accept = acc; d.len_err = lerr; d.len = len[10:0];
        exp_done.push_back(d);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (exp_stream.size() == 0 && exp_done.size() == 0) break;
            @(negedge CLK);
        end
        chk({tag, "_stream_drained"}, exp_stream.size(), 0);
        chk({tag, "_done_drained"}, exp_done.size(), 0);
    endtask

    task automatic set_hello();
        pay.delete();
        pay.push_back(8'h48); pay.push_back(8'h45); pay.push_back(8'h4C);
        pay.push_back(8'h4C); pay.push_back(8'h4F);
    endtask

    // Scoreboard side: compares every strobe and status pulse the DUT produces.
    int cyc = 0;
    int last_tv = 0;
    int tv_in_frame = 0;
    always @(negedge CLK) begin
        beat_t s;
        done_t d;
        cyc++;
        if (reset) begin
            tv_in_frame = 0;
        end else begin
            if (M_AXIS_TVALID) begin
                chk("tvalid_expected", exp_stream.size() != 0, 1);
                if (exp_stream.size() != 0) begin
                    s = exp_stream.pop_front();
                    chk("tdata", M_AXIS_TDATA, s.data);
                    chk("tlast", M_AXIS_TLAST, s.last);
                end
                if (tv_in_frame > 0) chk("tvalid_spacing", cyc - last_tv, 4);
                last_tv = cyc;
                tv_in_frame++;
            end else if (M_AXIS_TLAST) begin
                chk("tlast_without_tvalid", M_AXIS_TLAST, 0);
            end
            if (RX_DONE) begin
                chk("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) begin
                    d = exp_done.pop_front();
                    if (d.fcs_care) chk("rx_fcs_ok", RX_FCS_OK, d.fcs_ok);
                    chk("rx_accept", RX_ACCEPT, d.accept);
                    chk("rx_len_err", RX_LEN_ERR, d.len_err);
                    chk("rx_len", RX_LEN, d.len);
                end
                tv_in_frame = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        CRS_DV = 1'b0;
        RXD    = 2'b00;
        repeat (5) @(negedge CLK);
        chk("reset_stream_out", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, 0);
        chk("reset_status_out", {RX_DONE, RX_FCS_OK, RX_ACCEPT, RX_LEN_ERR, RX_LEN}, 0);
        reset = 1'b0;
        repeat (5) @(negedge CLK);

        // Valid HELLO frame
        set_hello();
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd13);
        expect_stream(5, 1);
        expect_done(1, 1, 1, 0, 5);
        send(frm.size(), 0, 1);
        wait_drain("hello");

        // One payload bit flipped after FCS computed
        frm[44] = frm[44] ^ 8'h01;
        expect_stream(5, 1);
        expect_done(0, 1, 1, 0, 5);
        send(frm.size(), 0, 1);
        wait_drain("bad_fcs");

        // Wrong port, wrong IP, ARP ethertype: filtered, FCS still good
        build(MAC, 16'h0800, 8'h11, IP, 16'h1234, 16'd13);
        expect_done(1, 1, 0, 0, 0);
        send(frm.size(), 0, 1);
        wait_drain("bad_port");
        build(MAC, 16'h0800, 8'h11, 32'hC0A80199, PORT, 16'd13);
        expect_done(1, 1, 0, 0, 0);
        send(frm.size(), 0, 1);
        wait_drain("bad_ip");
        build(MAC, 16'h0806, 8'h11, IP, PORT, 16'd13);
        expect_done(1, 1, 0, 0, 0);
        send(frm.size(), 0, 1);
        wait_drain("arp");

        // Broadcast destination MAC is accepted
        build(48'hFFFFFFFFFFFF, 16'h0800, 8'h11, IP, PORT, 16'd13);
        expect_stream(5, 1);
        expect_done(1, 1, 1, 0, 5);
        send(frm.size(), 0, 1);
        wait_drain("broadcast");

        // UDP length boundaries: exactly 8 (empty) and below 8
        pay.delete();
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd8);
        expect_done(1, 1, 1, 0, 0);
        send(frm.size(), 0, 1);
        wait_drain("udp_len_8");
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd5);
        expect_done(1, 1, 1, 1, 0);
        send(frm.size(), 0, 1);
        wait_drain("udp_len_5");

        // Carrier lost after 3 of 10 payload bytes
        for (int i = 0; i < 10; i++) pay.push_back(8'h30 + 8'(i));
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd18);
        expect_stream(3, 0);
        expect_done(crc_over(45) == RESID, 1, 0, 1, 3);
        send(45, 0, 1);
        wait_drain("truncated");

        // Preamble containing dibit 10: silently discarded
        set_hello();
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd13);
        send(frm.size(), 1, 1);
        wait_drain("bad_preamble");

        // Reset during payload, carrier still high with an SFD-like pattern afterwards
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'hA0 + 8'(i));
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd18);
        expect_stream(3, 0);
        send(45, 0, 0);
        for (int i = 0; i < 3; i++) drive(2'b00, 1'b1);
        @(negedge CLK);
        reset = 1'b1;
        RXD   = 2'b01;
        repeat (2) @(negedge CLK);
        chk("midreset_stream_out", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, 0);
        chk("midreset_status_out", {RX_DONE, RX_FCS_OK, RX_ACCEPT, RX_LEN_ERR, RX_LEN}, 0);
        reset = 1'b0;
        drive(2'b01, 1'b1); drive(2'b01, 1'b1); drive(2'b01, 1'b1); drive(2'b11, 1'b1);
        for (int i = 0; i < 80; i++) drive(2'b01, 1'b1);
        for (int i = 0; i < 48; i++) drive(2'b00, 1'b0);
        wait_drain("mid_reset");

        // Following valid frame after the reset
        set_hello();
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd13);
        expect_stream(5, 1);
        expect_done(1, 1, 1, 0, 5);
        send(frm.size(), 0, 1);
        wait_drain("after_reset");

        // Back-to-back frames with 12-byte gap
        expect_stream(5, 1);
        expect_done(1, 1, 1, 0, 5);
        expect_stream(5, 1);
        expect_done(1, 1, 1, 0, 5);
        send(frm.size(), 0, 1);
        send(frm.size(), 0, 1);
        wait_drain("back_to_back");

        // Oversize frame: the 1519th byte after SFD aborts with a length error
        pay.delete();
        for (int i = 0; i < 1480; i++) pay.push_back(i[7:0]);
        build(MAC, 16'h0800, 8'h11, IP, PORT, 16'd1488);
        expect_stream(1476, 0);
        expect_done(0, 0, 1, 1, 1476);
        send(frm.size(), 0, 1);
        wait_drain("oversize");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
